// File: rtl/vram_pkg.sv
// Shared types and constants for the VRAM port arbiter and its helpers.
package vram_pkg;

    localparam int VRAM_ADDR_W = 16;
    localparam int VRAM_DATA_W = 16;

    // Data returned alongside dr_err when a read is abandoned.
    localparam logic [15:0] VRAM_RD_ERR_DATA = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR       = 2'd1,
        ST_RD_ISSUE = 2'd2,
        ST_RD_WAIT  = 2'd3
    } vram_arb_state_t;

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done_o is high while the count rests at zero.
module cycle_timer #(
    parameter int W    = 8,
    parameter int INIT = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         done_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= W'(INIT);
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/vram_arbiter.sv
// Shares the SDRAM FIFO port between the board writer and the display fetcher:
// reads lead during active video, writes lead during vertical sync.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W       = VRAM_ADDR_W,
    parameter int DATA_W       = VRAM_DATA_W,
    parameter int STARVE_LIMIT = 64,
    parameter int RD_TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vs,
    input  logic              gw_req,
    input  logic [ADDR_W-1:0] gw_addr,
    input  logic [DATA_W-1:0] gw_data,
    output logic              gw_ack,
    input  logic              dr_req,
    input  logic [ADDR_W-1:0] dr_addr,
    output logic              dr_ack,
    output logic              dr_valid,
    output logic [DATA_W-1:0] dr_data,
    output logic              dr_err,
    output logic              write,
    output logic [ADDR_W-1:0] writeaddr,
    output logic [DATA_W-1:0] writedata,
    input  logic              wr_full,
    output logic              read,
    output logic [ADDR_W-1:0] readaddr,
    input  logic [DATA_W-1:0] readdata,
    input  logic              rd_empty,
    output logic [3:0]        err_cnt
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int RDTO_W   = $clog2(RD_TIMEOUT + 1);

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    vram_arb_state_t state_q;
    logic            vs_q;
    logic            wr_elig, rd_elig;
    logic            grant_wr, grant_rd;
    logic            lo_elig, lo_grant;
    logic            vs_toggle;
    logic            starve, rd_done;

    always_comb begin
        wr_elig  = gw_req && !wr_full;
        rd_elig  = dr_req;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (state_q == ST_IDLE) begin
            if (wr_elig && rd_elig) begin
                // vs picks the favoured side; a raised starve flag flips it.
                grant_wr = vs ^ starve;
                grant_rd = !(vs ^ starve);
            end else begin
                grant_wr = wr_elig;
                grant_rd = rd_elig;
            end
        end
        lo_elig   = vs ? rd_elig  : wr_elig;
        lo_grant  = vs ? grant_rd : grant_wr;
        vs_toggle = (vs != vs_q);
    end

    // Starve count runs down from STARVE_LIMIT on every denied low-priority cycle.
    cycle_timer #(.W(STARVE_W), .INIT(STARVE_LIMIT)) u_starve (
        .clk        (clk),
        .reset      (reset),
        .load_i     (vs_toggle || lo_grant),
        .load_val_i (STARVE_W'(STARVE_LIMIT)),
        .en_i       (lo_elig && !lo_grant),
        .done_o     (starve)
    );

    // Loaded during RD_ISSUE so it reaches zero on the last allowed RD_WAIT cycle.
    cycle_timer #(.W(RDTO_W), .INIT(RD_TIMEOUT - 1)) u_rd_timeout (
        .clk        (clk),
        .reset      (reset),
        .load_i     (state_q == ST_RD_ISSUE),
        .load_val_i (RDTO_W'(RD_TIMEOUT - 1)),
        .en_i       (state_q == ST_RD_WAIT),
        .done_o     (rd_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            vs_q      <= 1'b0;
            gw_ack    <= 1'b0;
            dr_ack    <= 1'b0;
            dr_valid  <= 1'b0;
            dr_data   <= '0;
            dr_err    <= 1'b0;
            write     <= 1'b0;
            writeaddr <= '0;
            writedata <= '0;
            read      <= 1'b0;
            readaddr  <= '0;
            err_cnt   <= 4'd0;
        end else begin
            vs_q     <= vs;
            write    <= 1'b0;
            gw_ack   <= 1'b0;
            read     <= 1'b0;
            dr_ack   <= 1'b0;
            dr_valid <= 1'b0;
            dr_err   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_wr) begin
                        state_q   <= ST_WR;
                        write     <= 1'b1;
                        gw_ack    <= 1'b1;
                        writeaddr <= gw_addr;
                        writedata <= gw_data;
                    end else if (grant_rd) begin
                        state_q  <= ST_RD_ISSUE;
                        read     <= 1'b1;
                        dr_ack   <= 1'b1;
                        readaddr <= dr_addr;
                    end
                end
                ST_WR:       state_q <= ST_IDLE;
                ST_RD_ISSUE: state_q <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    if (!rd_empty) begin
                        state_q  <= ST_IDLE;
                        dr_valid <= 1'b1;
                        dr_data  <= readdata;
                    end else if (rd_done) begin
                        state_q  <= ST_IDLE;
                        dr_valid <= 1'b1;
                        dr_err   <= 1'b1;
                        dr_data  <= DATA_W'(VRAM_RD_ERR_DATA);
                        err_cnt  <= sat_inc4(err_cnt);
                    end
                end
                default:     state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: single transfers, contention, starvation,
// FIFO-full blocking, read timeout saturation and reset mid-read.
`timescale 1ns/1ps
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 16;
    localparam int STARVE_LIMIT = 64;
    localparam int RD_TIMEOUT   = 255;

    logic              clk = 1'b0;
    logic              reset, vs;
    logic              gw_req, gw_ack, dr_req, dr_ack, dr_valid, dr_err;
    logic [ADDR_W-1:0] gw_addr, dr_addr, writeaddr, readaddr;
    logic [DATA_W-1:0] gw_data, dr_data, writedata, readdata;
    logic              write, wr_full, read, rd_empty;
    logic [3:0]        err_cnt;

    int n_vec  = 0;
    int n_miss = 0;
    int wr_seen;

    always #5 clk = ~clk;

    vram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .vs(vs),
        .gw_req(gw_req), .gw_addr(gw_addr), .gw_data(gw_data), .gw_ack(gw_ack),
        .dr_req(dr_req), .dr_addr(dr_addr), .dr_ack(dr_ack),
        .dr_valid(dr_valid), .dr_data(dr_data), .dr_err(dr_err),
        .write(write), .writeaddr(writeaddr), .writedata(writedata), .wr_full(wr_full),
        .read(read), .readaddr(readaddr), .readdata(readdata), .rd_empty(rd_empty),
        .err_cnt(err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Raise dr_req in the current IDLE cycle while the writer keeps requesting.
    task automatic starve_round(input string tag);
        int  waited;
        int  wr_cnt;
        bit  got;
        dr_req = 1'b1;
        waited = 0; wr_cnt = 0; got = 1'b0;
        while (!got && waited < 4 * STARVE_LIMIT) begin
            @(negedge clk);
            waited++;
            if (dr_ack) got = 1'b1;
            else if (write) wr_cnt++;
        end
        chk($sformatf("%s_ack_cycle", tag), waited, STARVE_LIMIT + 1);
        chk($sformatf("%s_writes", tag), wr_cnt, STARVE_LIMIT / 2);
        dr_req = 1'b0;
        waited = 0; got = 1'b0;
        while (!got && waited < 8) begin
            @(negedge clk);
            waited++;
            if (dr_valid) got = 1'b1;
        end
        chk($sformatf("%s_valid", tag), {got, dr_err}, 2'b10);
        chk($sformatf("%s_data", tag), dr_data, 16'h1234);
    endtask

    // One abandoned read starting from an IDLE cycle.
    task automatic do_timeout(input int idx, input logic [3:0] exp_cnt);
        dr_req  = 1'b1;
        dr_addr = 16'h0100 + 16'(idx);
        cyc(1);
        dr_req = 1'b0;
        cyc(RD_TIMEOUT);
        chk($sformatf("to%0d_early", idx), dr_valid, 1'b0);
        cyc(1);
        chk($sformatf("to%0d_flags", idx), {dr_valid, dr_err}, 2'b11);
        chk($sformatf("to%0d_data", idx), dr_data, 16'h0000);
        chk($sformatf("to%0d_errcnt", idx), err_cnt, exp_cnt);
    endtask

    initial begin
        reset = 1'b1; vs = 1'b0;
        gw_req = 1'b0; gw_addr = '0; gw_data = '0;
        dr_req = 1'b0; dr_addr = '0;
        wr_full = 1'b0; readdata = '0; rd_empty = 1'b1;
        cyc(3);
        chk("rst_strobes", {write, read, gw_ack, dr_ack, dr_valid, dr_err}, 6'b0);
        chk("rst_addr", {writeaddr, readaddr}, 32'h0);
        chk("rst_data", {writedata, dr_data}, 32'h0);
        chk("rst_errcnt", err_cnt, 4'd0);
        chk("rst_state", dut.state_q, ST_IDLE);
        reset = 1'b0;
        cyc(2);

        // Write only
        gw_req = 1'b1; gw_addr = 16'h0002; gw_data = 16'h0002;
        cyc(1);
        chk("wr_strobe", {write, gw_ack, read}, 3'b110);
        chk("wr_addr", writeaddr, 16'h0002);
        chk("wr_data", writedata, 16'h0002);
        gw_req = 1'b0;
        cyc(1);
        chk("wr_pulse_end", {write, gw_ack}, 2'b00);
        chk("wr_idle", dut.state_q, ST_IDLE);
        cyc(1);

        // Read only, FIFO answers two cycles after the read strobe
        dr_req = 1'b1; dr_addr = 16'h0003;
        cyc(1);
        chk("rd_strobe", {read, dr_ack, write}, 3'b110);
        chk("rd_addr", readaddr, 16'h0003);
        dr_req = 1'b0;
        cyc(1);
        chk("rd_wait", {read, dr_ack, dr_valid}, 3'b000);
        cyc(1);
        rd_empty = 1'b0; readdata = 16'h0003;
        chk("rd_not_yet", dr_valid, 1'b0);
        cyc(1);
        chk("rd_valid", {dr_valid, dr_err}, 2'b10);
        chk("rd_data", dr_data, 16'h0003);
        rd_empty = 1'b1;
        cyc(1);
        chk("rd_valid_pulse", dr_valid, 1'b0);
        cyc(1);

        // Contention during active video: read first
        readdata = 16'h00A5; rd_empty = 1'b0;
        gw_req = 1'b1; gw_addr = 16'h0010; gw_data = 16'h1111;
        dr_req = 1'b1; dr_addr = 16'h0020;
        cyc(1);
        chk("c0_first", {read, write}, 2'b10);
        chk("c0_rdaddr", readaddr, 16'h0020);
        dr_req = 1'b0;
        cyc(1);
        chk("c0_hold", {read, write}, 2'b00);
        cyc(1);
        chk("c0_valid", {dr_valid, write}, 2'b10);
        chk("c0_rddata", dr_data, 16'h00A5);
        cyc(1);
        chk("c0_second", {write, read}, 2'b10);
        chk("c0_wraddr", writeaddr, 16'h0010);
        gw_req = 1'b0; rd_empty = 1'b1;
        cyc(2);

        // Contention during vertical sync: write first
        vs = 1'b1;
        cyc(2);
        gw_req = 1'b1; gw_addr = 16'h0030; gw_data = 16'h3333;
        dr_req = 1'b1; dr_addr = 16'h0040; rd_empty = 1'b0; readdata = 16'h5A5A;
        cyc(1);
        chk("c1_first", {write, read}, 2'b10);
        chk("c1_wrdata", writedata, 16'h3333);
        gw_req = 1'b0;
        cyc(1);
        chk("c1_gap", {write, read}, 2'b00);
        cyc(1);
        chk("c1_second", {read, dr_ack, write}, 3'b110);
        chk("c1_rdaddr", readaddr, 16'h0040);
        dr_req = 1'b0;
        cyc(2);
        chk("c1_valid", {dr_valid, dr_err}, 2'b10);
        chk("c1_data", dr_data, 16'h5A5A);

        // Starvation: continuous writer during vs; second round shows the count restarted
        readdata = 16'h1234;
        gw_req = 1'b1; gw_addr = 16'h0044; gw_data = 16'h4444;
        starve_round("sv1");
        starve_round("sv2");
        gw_req = 1'b0;
        cyc(2);

        // FIFO full blocks the writer even while it has priority
        wr_full = 1'b1; gw_req = 1'b1; gw_addr = 16'h0050; gw_data = 16'h5555;
        dr_req = 1'b1; dr_addr = 16'h0060; readdata = 16'h0F0F;
        cyc(1);
        chk("full_rd_granted", {read, write}, 2'b10);
        dr_req = 1'b0;
        wr_seen = 0;
        repeat (6) begin
            cyc(1);
            if (write) wr_seen++;
        end
        chk("full_no_write", wr_seen, 0);
        wr_full = 1'b0;
        cyc(1);
        chk("full_release", {write, writeaddr}, {1'b1, 16'h0050});
        gw_req = 1'b0; rd_empty = 1'b1; readdata = 16'hBEEF;
        vs = 1'b0;
        cyc(2);

        // Read timeouts, error count saturates at 15
        for (int i = 1; i <= 16; i++) begin
            do_timeout(i, (i > 15) ? 4'd15 : 4'(i));
        end
        cyc(1);

        // Reset while waiting on a read; the held request is re-granted afterwards
        dr_req = 1'b1; dr_addr = 16'h0077;
        cyc(1);
        chk("mr_issue", read, 1'b1);
        cyc(2);
        chk("mr_waiting", dut.state_q, ST_RD_WAIT);
        reset = 1'b1;
        cyc(1);
        chk("mr_strobes", {write, read, gw_ack, dr_ack, dr_valid, dr_err}, 6'b0);
        chk("mr_regs", {writeaddr, readaddr}, 32'h0);
        chk("mr_errcnt", err_cnt, 4'd0);
        chk("mr_state", dut.state_q, ST_IDLE);
        reset = 1'b0;
        cyc(1);
        chk("mr_regrant", {read, dr_ack}, 2'b11);
        chk("mr_rdaddr", readaddr, 16'h0077);
        dr_req = 1'b0; rd_empty = 1'b0; readdata = 16'h7777;
        cyc(2);
        chk("mr_valid", {dr_valid, dr_err}, 2'b10);
        chk("mr_data", dr_data, 16'h7777);
        rd_empty = 1'b1;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
